controle_bomba: RTL

//  Game controller downstream of the password comparator. Arms the bomb and runs a

---
 rtl/controle_bomba_if.sv | 21 ++
 rtl/controle_bomba.sv | 84 ++++++++
 2 files changed

// File: rtl/controle_bomba_if.sv
// controle_bomba_if: buttons, comparator verdict and display/LED outputs of the bomb controller
interface controle_bomba_if;
  logic       iniciar;
  logic       enter;
  logic       sinalvitoria;
  logic       start_comparador;
  logic [6:0] tempo_restante;
  logic [2:0] tentativas_rest;
  logic       armada;
  logic       desarmada;
  logic       explodiu;
  logic       erro_pulso;
  modport master (
    output iniciar, enter, sinalvitoria, start_comparador,
    input  tempo_restante, tentativas_rest, armada, desarmada, explodiu, erro_pulso
  );
  modport slave (
    input  iniciar, enter, sinalvitoria, start_comparador,
    output tempo_restante, tentativas_rest, armada, desarmada, explodiu, erro_pulso
  );
endinterface

// File: rtl/controle_bomba.sv
// controle_bomba: arms the bomb, runs the seconds countdown and resolves comparator verdicts on ENTER
module controle_bomba #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int TEMPO_INICIAL  = 60,
  parameter int MAX_TENTATIVAS = 3,
  parameter int PENALIDADE     = 10
) (
  input logic clk,
  input logic reset,
  controle_bomba_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {OCIOSO, ARMADA, DESARMADA, EXPLODIDA} estado_t;
  estado_t estado, prox;
  logic [2:0] ini_s, ent_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0] tempo, tempo_n;
  logic [2:0] tent, tent_n;
  logic [7:0] d;
  logic ini_edge, ent_edge, tick, erro_n;
  logic armada_r, desarmada_r, explodiu_r, erro_r;
  assign ini_edge = ini_s[1] & ~ini_s[2];
  assign ent_edge = ent_s[1] & ~ent_s[2];
  assign tick = (estado == ARMADA) && (cnt == CW'(TICK_DIV - 1));
  // signed 8-bit view so a penalty past zero shows up as a negative result
  assign d = {1'b0, tempo} - 8'(PENALIDADE) - {7'd0, tick};
  always_comb begin
    prox = estado;
    tempo_n = tempo;
    tent_n = tent;
    cnt_n = cnt;
    erro_n = 1'b0;
    if (estado == OCIOSO && ini_edge) begin
      prox = ARMADA;
      tempo_n = 7'(TEMPO_INICIAL);
      tent_n = 3'(MAX_TENTATIVAS);
      cnt_n = '0;
    end else if (estado == ARMADA) begin
      cnt_n = tick ? '0 : cnt + CW'(1);
      if (ent_edge && bus.sinalvitoria) begin
        prox = DESARMADA;
      end else if (ent_edge && bus.start_comparador) begin
        tent_n = (tent != 3'd0) ? tent - 3'd1 : 3'd0;
        erro_n = 1'b1;
        tempo_n = d[7] ? 7'd0 : d[6:0];
        prox = (tent_n == 3'd0 || tempo_n == 7'd0) ? EXPLODIDA : ARMADA;
      end else if (tick) begin
        tempo_n = tempo - 7'd1;
        prox = (tempo_n == 7'd0) ? EXPLODIDA : ARMADA;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      tempo <= 7'(TEMPO_INICIAL);
      tent <= 3'(MAX_TENTATIVAS);
      cnt <= '0;
      ini_s <= '0;
      ent_s <= '0;
      armada_r <= 1'b0;
      desarmada_r <= 1'b0;
      explodiu_r <= 1'b0;
      erro_r <= 1'b0;
    end else begin
      estado <= prox;
      tempo <= tempo_n;
      tent <= tent_n;
      cnt <= cnt_n;
      ini_s <= {ini_s[1:0], bus.iniciar};
      ent_s <= {ent_s[1:0], bus.enter};
      armada_r <= prox == ARMADA;
      desarmada_r <= prox == DESARMADA;
      explodiu_r <= prox == EXPLODIDA;
      erro_r <= erro_n;
    end
  end
  assign bus.tempo_restante = tempo;
  assign bus.tentativas_rest = tent;
  assign bus.armada = armada_r;
  assign bus.desarmada = desarmada_r;
  assign bus.explodiu = explodiu_r;
  assign bus.erro_pulso = erro_r;
endmodule
